hamming_secded_tx: RTL and testbench

- SECDED Hamming encoder and serial transmitter. It is the sending end of the 8-bit protected-word link.
- Takes a 4-bit data nibble through a valid/ready handshake and builds the 8-bit even-parity SECDED codeword. The bit layout is the one the receive-side corrector expects.
- An optional error mask is XORed in so single- and double-error paths can be exercised.
- The codeword is presented in parallel and also shifted out on a UART-style serial line.

---
 rtl/hamming_secded_tx.sv | 170 +++++++++++++++++
 tb/tb_hamming_secded_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_tx.sv
// SECDED Hamming encoder with UART-style serial transmitter.
// Accepts a 4-bit nibble via valid/ready, builds the 8-bit even-parity SECDED
// codeword {g0,w3,w2,w1,p2,w0,p1,p0}, XORs in an error mask, presents it in
// parallel and shifts it out LSB first framed by one start and one stop bit.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   data_in    data nibble {w3,w2,w1,w0}
//   err_mask   bit-flip mask XORed into the codeword (0 = clean)
//   in_valid   data_in/err_mask valid
//   in_ready   block can accept a word (IDLE), decoded from the state register
//   codeword   transmitted codeword (after mask), held until next accept
//   cw_valid   one-cycle pulse: codeword updated
//   tx_serial  serial line, idle high
//   tx_busy    frame in progress
//   done       one-cycle pulse: frame complete
module hamming_secded_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in,
    input  logic [7:0] err_mask,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] codeword,
    output logic       cw_valid,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       done
);

    localparam int unsigned BAUD_W = 10;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned CW_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CW_W-1:0]     cw_q, cw_d;
    logic                cw_valid_q, cw_valid_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                baud_wrap;
    logic [BIT_W-1:0]    bit_nxt;

    // Parity bits cover the classic Hamming(7,4) positions; g0 makes the
    // whole byte even parity and is computed before any mask is applied.
    function automatic logic [CW_W-1:0] encode(input logic [3:0] w);
        logic [CW_W-1:0] c;
        c[0] = w[0] ^ w[1] ^ w[3];
        c[1] = w[0] ^ w[2] ^ w[3];
        c[2] = w[0];
        c[3] = w[1] ^ w[2] ^ w[3];
        c[4] = w[1];
        c[5] = w[2];
        c[6] = w[3];
        c[7] = ^c[6:0];
        return c;
    endfunction

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            cw_q       <= '0;
            cw_valid_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            cw_q       <= cw_d;
            cw_valid_q <= cw_valid_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign baud_wrap = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign bit_nxt   = bit_q + BIT_W'(1);

    // Next-state logic; the line value for the next bit period is loaded on
    // the same edge the state advances so tx_serial stays glitch-free.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        cw_d       = cw_q;
        cw_valid_d = 1'b0;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = START;
                    cw_d       = encode(data_in) ^ err_mask;
                    cw_valid_d = 1'b1;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    baud_d     = '0;
                    bit_d      = '0;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_d = DATA;
                    baud_d  = '0;
                    tx_d    = cw_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(CW_W - 1)) begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = cw_q[bit_nxt];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign codeword  = cw_q;
    assign cw_valid  = cw_valid_q;
    assign tx_serial = tx_q;
    assign tx_busy   = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_hamming_secded_tx.sv
// Bench for hamming_secded_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
module tb_hamming_secded_tx;

    logic       clk;
    logic       rst;
    logic [3:0] data_in;
    logic [7:0] err_mask;
    logic       in_valid4, in_valid1;
    logic       in_ready4, in_ready1;
    logic [7:0] codeword4, codeword1;
    logic       cw_valid4, cw_valid1;
    logic       tx4, tx1;
    logic       busy4, busy1;
    logic       done4, done1;

    int checks;
    int failures;

    hamming_secded_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .data_in(data_in), .err_mask(err_mask),
        .in_valid(in_valid4), .in_ready(in_ready4), .codeword(codeword4),
        .cw_valid(cw_valid4), .tx_serial(tx4), .tx_busy(busy4), .done(done4)
    );

    hamming_secded_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .err_mask(err_mask),
        .in_valid(in_valid1), .in_ready(in_ready1), .codeword(codeword1),
        .cw_valid(cw_valid1), .tx_serial(tx1), .tx_busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic [7:0] mask;
        logic [7:0] exp_cw;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: data sits at Hamming positions 3,5,6,7; parity bit at position
    // 2^p covers every position whose index has bit p set; bit 7 is overall parity.
    function automatic logic [7:0] model_cw(input logic [3:0] d, input logic [7:0] m);
        logic [7:0] c;
        int dpos [4];
        logic par;
        dpos = '{3, 5, 6, 7};
        c = '0;
        for (int k = 0; k < 4; k++) c[dpos[k] - 1] = d[k];
        for (int p = 0; p < 3; p++) begin
            par = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if ((pos & (1 << p)) != 0) par = par ^ c[pos - 1];
            c[(1 << p) - 1] = par;
        end
        c[7] = ($countones(c[6:0]) % 2) == 1;
        return c ^ m;
    endfunction

    function automatic logic g_rdy(input int sel);  return sel != 0 ? in_ready1 : in_ready4; endfunction
    function automatic logic g_cwv(input int sel);  return sel != 0 ? cw_valid1 : cw_valid4; endfunction
    function automatic logic g_tx(input int sel);   return sel != 0 ? tx1 : tx4;             endfunction
    function automatic logic g_busy(input int sel); return sel != 0 ? busy1 : busy4;         endfunction
    function automatic logic g_done(input int sel); return sel != 0 ? done1 : done4;         endfunction
    function automatic logic [7:0] g_cw(input int sel); return sel != 0 ? codeword1 : codeword4; endfunction

    task automatic set_valid(input int sel, input logic v);
        if (sel != 0) in_valid1 = v;
        else          in_valid4 = v;
    endtask

    // Starts at a falling edge with the DUT idle, ends at the falling edge of
    // the done cycle with in_valid dropped. With noise, in_valid stays high and
    // the inputs churn for the whole frame.
    task automatic send(input int sel, input logic [3:0] d, input logic [7:0] m,
                        input logic [7:0] exp, input bit noise, input string tag);
        int n;
        int wave_err;
        int side_err;
        int idx;
        logic eb;
        logic line [64];
        logic [7:0] rec;
        n = (sel != 0) ? 1 : 4;
        data_in  = d;
        err_mask = m;
        set_valid(sel, 1'b1);
        chk({tag, "_ready_pre"}, 32'(g_rdy(sel)), 32'd1);
        @(negedge clk);
        chk({tag, "_cw"},       32'(g_cw(sel)),   32'(exp));
        chk({tag, "_cw_valid"}, 32'(g_cwv(sel)),  32'd1);
        chk({tag, "_busy1"},    32'(g_busy(sel)), 32'd1);
        chk({tag, "_ready1"},   32'(g_rdy(sel)),  32'd0);
        if (!noise) set_valid(sel, 1'b0);
        wave_err = 0;
        side_err = 0;
        for (int c = 1; c <= 10 * n; c++) begin
            if (c > 1) begin
                @(negedge clk);
                if (noise) begin
                    data_in  = 4'($urandom);
                    err_mask = 8'($urandom);
                end
                if (g_rdy(sel) || g_cwv(sel) || g_done(sel) || !g_busy(sel)) side_err++;
                if (g_cw(sel) !== exp) side_err++;
            end
            line[c] = g_tx(sel);
            idx = (c - 1) / n;
            eb = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : exp[idx - 1];
            if (line[c] !== eb) wave_err++;
        end
        chk({tag, "_wave_errs"}, 32'(wave_err), 32'd0);
        chk({tag, "_side_errs"}, 32'(side_err), 32'd0);
        for (int i = 0; i < 8; i++) rec[i] = line[1 + n * (1 + i) + n / 2];
        chk({tag, "_rx_byte"}, 32'(rec), 32'(exp));
        @(negedge clk);
        set_valid(sel, 1'b0);
        chk({tag, "_done"},      32'(g_done(sel)), 32'd1);
        chk({tag, "_busy_end"},  32'(g_busy(sel)), 32'd0);
        chk({tag, "_ready_end"}, 32'(g_rdy(sel)),  32'd1);
        chk({tag, "_tx_idle"},   32'(g_tx(sel)),   32'd1);
        chk({tag, "_cw_hold"},   32'(g_cw(sel)),   32'(exp));
    endtask

    vec_t vecs [7];

    initial begin
        logic [3:0] rd;
        logic [7:0] rm;
        int bad;
        checks    = 0;
        failures  = 0;
        vecs[0] = '{4'hB, 8'h00, 8'h55};
        vecs[1] = '{4'h0, 8'h00, 8'h00};
        vecs[2] = '{4'hF, 8'h00, 8'hFF};
        vecs[3] = '{4'h1, 8'h00, 8'h87};
        vecs[4] = '{4'hB, 8'h04, 8'h51};
        vecs[5] = '{4'hB, 8'h03, 8'h56};
        vecs[6] = '{4'hB, 8'h80, 8'hD5};

        rst = 1'b1;
        data_in = '0;
        err_mask = '0;
        in_valid4 = 1'b0;
        in_valid1 = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst%0d_cw", s),    32'(g_cw(s)),   32'd0);
            chk($sformatf("rst%0d_cwv", s),   32'(g_cwv(s)),  32'd0);
            chk($sformatf("rst%0d_tx", s),    32'(g_tx(s)),   32'd1);
            chk($sformatf("rst%0d_busy", s),  32'(g_busy(s)), 32'd0);
            chk($sformatf("rst%0d_done", s),  32'(g_done(s)), 32'd0);
            chk($sformatf("rst%0d_ready", s), 32'(g_rdy(s)),  32'd1);
        end
        rst = 1'b0;
        @(negedge clk);

        // Encoding sweep and error injection at 4 clocks/bit.
        for (int v = 0; v < 7; v++) begin
            send(0, vecs[v].data, vecs[v].mask, vecs[v].exp_cw, 1'b0, $sformatf("vec%0d", v));
            @(negedge clk);
            chk($sformatf("vec%0d_idle_hold", v), 32'(codeword4), 32'(vecs[v].exp_cw));
            chk($sformatf("vec%0d_idle_cwv", v),  32'(cw_valid4), 32'd0);
        end

        // Busy rejection: churn inputs during the frame, next frame takes done-cycle data.
        send(0, 4'hB, 8'h00, 8'h55, 1'b1, "busy_a");
        send(0, 4'h1, 8'h00, 8'h87, 1'b0, "busy_b");

        // Reset during data bit 3 (cycles 17..20 after accept at 4 clocks/bit).
        data_in = 4'hB;
        err_mask = 8'h00;
        in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_tx",    32'(tx4),       32'd1);
        chk("midrst_busy",  32'(busy4),     32'd0);
        chk("midrst_ready", 32'(in_ready4), 32'd1);
        chk("midrst_cw",    32'(codeword4), 32'd0);
        chk("midrst_done",  32'(done4),     32'd0);
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done4 || !tx4 || busy4) bad++;
        end
        chk("midrst_quiet", 32'(bad), 32'd0);
        send(0, 4'hB, 8'h00, 8'h55, 1'b0, "post_rst");

        // Back-to-back at 1 clock/bit.
        send(1, 4'h1, 8'h00, 8'h87, 1'b0, "b2b_a");
        send(1, 4'hF, 8'h00, 8'hFF, 1'b0, "b2b_b");

        // Randomised frames against the reference model.
        for (int r = 0; r < 16; r++) begin
            rd = 4'($urandom);
            rm = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
            send(1, rd, rm, model_cw(rd, rm), 1'b0, $sformatf("rnd1_%0d", r));
        end
        for (int r = 0; r < 6; r++) begin
            rd = 4'($urandom);
            rm = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
            send(0, rd, rm, model_cw(rd, rm), ($urandom_range(0, 1) != 0), $sformatf("rnd4_%0d", r));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
